// File: rtl/pim_lut_seq.sv
// Sequencer feeding the PIM LUT compare unit and the accumulator file.
// Define PIM_LUT_SEQ_SKIP_EN to scan only the accumulators selected by the mask.
module pim_lut_seq #(
    parameter int NUM_ACC = 16,
    parameter int IDX_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_x,
    input  logic                      i_start,
    input  logic [NUM_ACC*IDX_W-1:0]  i_acc_offset,
    input  logic [NUM_ACC-1:0]        i_acc_mask,
    input  logic                      i_abort,
    input  logic                      i_row_valid,
    output logic                      o_row_ready,
    input  logic [NUM_ACC*16-1:0]     i_row_data,
    output logic [NUM_ACC*16-1:0]     o_lut_data,
    output logic [NUM_ACC*IDX_W-1:0]  o_lut_offset,
    output logic [IDX_W-1:0]          o_acc_idx,
    input  logic [15:0]               i_lut_result,
    input  logic [NUM_ACC-1:0]        i_lut_result_en,
    output logic [NUM_ACC-1:0]        o_acc_wr_en,
    output logic [15:0]               o_acc_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        PRIME,
        SCAN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [NUM_ACC-1:0]   mask;
    logic [IDX_W-1:0]     idx_nx;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     next_idx;
    logic                 start_ok;
    logic                 accept;
    logic                 capture;
    logic                 last;

`ifdef PIM_LUT_SEQ_SKIP_EN
    logic [NUM_ACC-1:0]   pend;
    logic [NUM_ACC-1:0]   rest;

    // Lowest set bit wins, so the scan stays in ascending order.
    function automatic logic [IDX_W-1:0] pick_first(input logic [NUM_ACC-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_ACC - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign rest      = pend & ~(NUM_ACC'(1) << o_acc_idx);
    assign last      = ~|rest;
    assign first_idx = pick_first(mask);
    assign next_idx  = pick_first(rest);
`else
    assign last      = (o_acc_idx == IDX_W'(NUM_ACC - 1));
    assign first_idx = '0;
    assign next_idx  = o_acc_idx + IDX_W'(1);
`endif

    assign start_ok    = (state == IDLE) && i_start && !i_abort;
    assign o_row_ready = (state == WAIT_ROW);
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = o_acc_idx;
        accept   = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = (|i_acc_mask) ? WAIT_ROW : DONE;
            end
            WAIT_ROW: begin
                if (i_row_valid) begin
                    accept   = 1'b1;
                    state_nx = PRIME;
                    idx_nx   = first_idx;
                end
            end
            PRIME: state_nx = SCAN;
            SCAN: begin
                capture = 1'b1;
                if (last) state_nx = DONE;
                else      idx_nx   = next_idx;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort drops the row handshake and the write captured this cycle.
        if (i_abort && state != IDLE) begin
            state_nx = IDLE;
            idx_nx   = o_acc_idx;
            accept   = 1'b0;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            o_lut_data    <= '0;
            o_lut_offset  <= '0;
            mask          <= '0;
            o_acc_idx     <= '0;
            o_acc_wr_en   <= '0;
            o_acc_wr_data <= '0;
        end else begin
            if (start_ok) begin
                o_lut_offset <= i_acc_offset;
                mask         <= i_acc_mask;
            end
            if (accept) o_lut_data <= i_row_data;
            o_acc_idx <= idx_nx;
            if (capture) begin
                o_acc_wr_data <= i_lut_result;
                o_acc_wr_en   <= i_lut_result_en & mask;
            end else begin
                o_acc_wr_en   <= '0;
            end
        end
    end

`ifdef PIM_LUT_SEQ_SKIP_EN
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x)       pend <= '0;
        else if (start_ok) pend <= i_acc_mask;
        else if (capture)  pend <= rest;
    end
`endif

endmodule

// File: doc/pim_lut_seq.md
Name: pim_lut_seq

Overview:
Sequencer for the PIM LUT compare datapath.
- Accepts a lookup command (per-accumulator 4-bit offsets plus participation mask) and one 256-bit LUT row (16 x 16-bit entries) via valid/ready.
- Holds offsets and row stable on the compare unit's inputs, then steps the accumulator index once per cycle.
- Registers each searched 16-bit result into a one-hot accumulator write. Sits between the PIM command decoder / DRAM read-data latch and the accumulator file.

Parameters:
NUM_ACC, 16, number of accumulators (fixed at 16; datapath sized for it)
IDX_W, 4, accumulator index width

Ports:
clk  input  1  clock
rst_x  input  1  async active-low reset
i_start  input  1  command pulse, sampled only in IDLE
i_acc_offset  input  64  16 x 4-bit LUT column offsets, latched on accepted start
i_acc_mask  input  16  accumulators participating, latched on accepted start
i_abort  input  1  synchronous abort
i_row_valid  input  1  LUT row data valid
o_row_ready  output  1  sequencer ready for LUT row
i_row_data  input  256  LUT row (entry k at bits 16k+15:16k)
o_lut_data  output  256  held row driven to compare unit data input
o_lut_offset  output  64  held offsets driven to compare unit offset input
o_acc_idx  output  4  accumulator index driven to compare unit
i_lut_result  input  16  compare unit searched data
i_lut_result_en  input  16  compare unit one-hot enable
o_acc_wr_en  output  16  one-hot accumulator write strobe
o_acc_wr_data  output  16  accumulator write data
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_x low): state IDLE. All outputs 0, including o_lut_data, o_lut_offset, o_acc_idx. Latched mask 0.
- States: IDLE, WAIT_ROW, PRIME, SCAN, DONE.
- IDLE:
  - i_start=1 latches offset and mask.
  - Mask nonzero: go to WAIT_ROW.
  - Mask zero: go directly to DONE; no row requested, no writes.
- WAIT_ROW:
  - o_row_ready=1.
  - On i_row_valid&o_row_ready (cycle H): row latched into o_lut_data (visible H+1); go to PRIME.
  - o_row_ready is 0 in all other states.
- PRIME: exactly one cycle (H+1). Lets the compare unit register data/offset. o_acc_idx = first scan index.
- SCAN:
  - Starts H+2; one index per cycle.
  - Result captured each SCAN cycle: o_acc_wr_data <= i_lut_result; o_acc_wr_en <= i_lut_result_en & mask. Write appears the following cycle.
  - o_acc_wr_en is 0 in all cycles without a capture.
  - After the last index, go to DONE.
- Index order: ascending. Without the optional feature, 0..15, all 16 cycles (H+2..H+17); masked-off indices produce an all-zero o_acc_wr_en.
- DONE: one cycle. o_done=1, coinciding with the last write. Return to IDLE; o_busy falls the next cycle.
- i_start outside IDLE: ignored, not queued.
- i_abort (any non-IDLE state): next state IDLE. The pending registered write from the current cycle is suppressed (o_acc_wr_en=0 next cycle). No o_done. o_lut_data/o_lut_offset retain their values.
- i_abort and i_start together in IDLE: abort wins, start dropped.
- i_row_valid outside WAIT_ROW: ignored.
- Reset mid-operation: immediate return to reset values; no done.
- o_lut_data and o_lut_offset stay stable from latch until the next accepted start/row, so the compare unit's registered copy is constant through SCAN.

Optional Feature:
- Macro: PIM_LUT_SEQ_SKIP_EN.
- Defined: SCAN visits only set mask bits, ascending. The next index comes from a priority encoder over the remaining mask. SCAN length = popcount(mask); DONE at H+2+popcount.
- Undefined: full 16-index scan as above, fixed latency DONE at H+18.

Test Plan:
- Reset: assert rst_x low mid-SCAN -> all outputs 0 immediately; after release, state IDLE, o_busy=0.
- Full scan: offset[4k+3:4k]=15-k, mask 16'hFFFF, row entry k=16'h1000+k, row accepted at H:
  - H+3..H+18: o_acc_wr_en=1<<k, o_acc_wr_data=16'h100F-k for k=0..15.
  - o_done at H+18.
- Partial mask 16'h0081, offsets all 4'h3, row entry 3=16'hBEEF:
  - writes only at idx 0 and 7, data 16'hBEEF.
  - Without the macro: done at H+18. With PIM_LUT_SEQ_SKIP_EN: writes at H+3 and H+4, done at H+4.
- Mask 16'h0000 start -> o_row_ready never asserted, o_done exactly one cycle after start, no writes.
- Backpressure: hold i_row_valid=0 for 10 cycles in WAIT_ROW -> o_row_ready stays 1, no writes, o_busy=1. Extra i_start pulses ignored.
- Abort at the third SCAN cycle -> exactly 2 writes (idx 0, 1), no o_done. IDLE next cycle. A subsequent start completes normally.
